// File: rtl/ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ex_stage                                                   |
// | Description : Execute stage. Single-cycle ALU and jump-target adder      |
// |               feeding a registered EX/MEM bundle. When EX_MULDIV_EN is   |
// |               defined, ops 10-13 run on a 32-step iterative MUL/DIV unit |
// |               that stalls upstream while busy; otherwise they return 0   |
// |               in a single cycle.                                         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] in_pc_data,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd_address,
    input  logic [3:0]      in_alu_rd_operator,
    input  logic            in_alu_rd_operand1_src,
    input  logic            in_alu_rd_operand2_src,
    input  logic            in_alu_pc_operand1_src,
    input  logic            in_next_pc_src,
    input  logic            in_reg_write_data_src,
    input  logic            in_reg_wren,
    input  logic            in_ram_wren,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] ram_write_data,
    output logic [4:0]      rd_address,
    output logic            reg_write_data_src,
    output logic            reg_wren,
    output logic            ram_wren,
    output logic            redirect,
    output logic [XLEN-1:0] jump_target
);

    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    logic            w_live;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_target_sum;
    logic [XLEN-1:0] w_target;

    assign w_live       = in_valid & ~flush;
    assign w_target_sum = (in_alu_pc_operand1_src ? in_rs1_data : in_pc_data) + in_imm;
    assign w_target     = {w_target_sum[XLEN-1:1], 1'b0};

    // Operand selection and single-cycle ALU; jumps override with the link address
    always_comb begin
        w_op1   = in_alu_rd_operand1_src ? in_pc_data : in_rs1_data;
        w_op2   = in_alu_rd_operand2_src ? in_imm : in_rs2_data;
        w_shamt = w_op2[4:0];
        w_alu   = '0;
        case (in_alu_rd_operator)
            4'd0:    w_alu = w_op1 + w_op2;
            4'd1:    w_alu = w_op1 - w_op2;
            4'd2:    w_alu = w_op1 << w_shamt;
            4'd3:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
            4'd4:    w_alu = {{(XLEN-1){1'b0}}, (w_op1 < w_op2)};
            4'd5:    w_alu = w_op1 ^ w_op2;
            4'd6:    w_alu = w_op1 >> w_shamt;
            4'd7:    w_alu = $unsigned($signed(w_op1) >>> w_shamt);
            4'd8:    w_alu = w_op1 | w_op2;
            4'd9:    w_alu = w_op1 & w_op2;
            4'd14:   w_alu = w_op2;
            default: w_alu = '0;   // 10-13 handled by the iterative unit, 15 is zero
        endcase
        if (in_next_pc_src) begin
            w_alu = in_pc_data + c_PC_STEP;
        end
    end

`ifdef EX_MULDIV_EN
    localparam int                c_CNT_W = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(XLEN - 1);
    localparam logic [0:0]        S_IDLE  = 1'b0;
    localparam logic [0:0]        S_BUSY  = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic                w_is_md;
    logic                w_issue;
    logic                w_done;

    logic [3:0]          r_md_op;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [c_CNT_W-1:0]  r_count;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_rs2;
    logic [4:0]          r_rd;
    logic                r_rwds;
    logic                r_reg_wren;
    logic                r_ram_wren;

    logic [2*XLEN-1:0]   w_addend;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [XLEN:0]       w_rem_shift;
    logic [XLEN:0]       w_rem_diff;
    logic                w_sub_ok;
    logic [XLEN-1:0]     w_rem_next;
    logic [XLEN-1:0]     w_quo_next;
    logic [XLEN-1:0]     w_md_result;

    // Jumps always take the single-cycle path, even if the operator is 10-13
    assign w_is_md = ~in_next_pc_src && (in_alu_rd_operator >= 4'd10) && (in_alu_rd_operator <= 4'd13);

    // FSM next-state, stall and issue/complete strobes
    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_live && w_is_md) begin
                    stall        = 1'b1;
                    w_issue      = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_count == c_LAST) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One shift-add step and one restoring-division step per BUSY cycle
    always_comb begin
        w_addend    = r_b[r_count] ? ({{XLEN{1'b0}}, r_a} << r_count) : '0;
        w_acc_next  = r_acc + w_addend;
        w_rem_shift = {r_rem, r_quo[XLEN-1]};
        w_rem_diff  = w_rem_shift - {1'b0, r_b};
        w_sub_ok    = (w_rem_shift >= {1'b0, r_b});
        w_rem_next  = w_sub_ok ? w_rem_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];
        w_quo_next  = {r_quo[XLEN-2:0], w_sub_ok};
        case (r_md_op)
            4'd10:   w_md_result = w_acc_next[XLEN-1:0];
            4'd11:   w_md_result = w_acc_next[2*XLEN-1:XLEN];
            4'd12:   w_md_result = w_quo_next;
            4'd13:   w_md_result = w_rem_next;
            default: w_md_result = '0;
        endcase
    end

    // Operand/control latch on issue, iteration registers while BUSY
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_op    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_count    <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rwds     <= 1'b0;
            r_reg_wren <= 1'b0;
            r_ram_wren <= 1'b0;
        end else if (w_issue) begin
            r_md_op    <= in_alu_rd_operator;
            r_a        <= w_op1;
            r_b        <= w_op2;
            r_count    <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_quo      <= w_op1;   // dividend bits shift out as quotient bits shift in
            r_rs2      <= in_rs2_data;
            r_rd       <= in_rd_address;
            r_rwds     <= in_reg_write_data_src;
            r_reg_wren <= in_reg_wren;
            r_ram_wren <= in_ram_wren;
        end else if (r_state == S_BUSY) begin
            r_count <= r_count + 1'b1;
            r_acc   <= w_acc_next;
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid          <= 1'b0;
            alu_result         <= '0;
            ram_write_data     <= '0;
            rd_address         <= '0;
            reg_write_data_src <= 1'b0;
            reg_wren           <= 1'b0;
            ram_wren           <= 1'b0;
            redirect           <= 1'b0;
            jump_target        <= '0;
        end
`ifdef EX_MULDIV_EN
        else if (w_done) begin
            out_valid          <= 1'b1;
            alu_result         <= w_md_result;
            ram_write_data     <= r_rs2;
            rd_address         <= r_rd;
            reg_write_data_src <= r_rwds;
            reg_wren           <= r_reg_wren;
            ram_wren           <= r_ram_wren;
            redirect           <= 1'b0;
        end else if (w_issue || (r_state == S_BUSY)) begin
            out_valid <= 1'b0;
            reg_wren  <= 1'b0;
            ram_wren  <= 1'b0;
            redirect  <= 1'b0;
        end
`endif
        else begin
            out_valid          <= w_live;
            alu_result         <= w_alu;
            ram_write_data     <= in_rs2_data;
            rd_address         <= in_rd_address;
            reg_write_data_src <= in_reg_write_data_src;
            reg_wren           <= w_live & in_reg_wren;
            ram_wren           <= w_live & in_ram_wren;
            redirect           <= w_live & in_next_pc_src;
            jump_target        <= w_target;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ex_stage                                                |
// | Description : Self-checking bench for ex_stage: vector table, hand       |
// |               sequences for jumps/flush/multi-cycle ops/reset, and a     |
// |               randomized run against a reference model.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, flush;
    logic [31:0] in_pc_data, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rd_address;
    logic [3:0]  in_alu_rd_operator;
    logic        in_alu_rd_operand1_src, in_alu_rd_operand2_src, in_alu_pc_operand1_src;
    logic        in_next_pc_src, in_reg_write_data_src, in_reg_wren, in_ram_wren;
    logic        stall, out_valid;
    logic [31:0] alu_result, ram_write_data, jump_target;
    logic [4:0]  rd_address;
    logic        reg_write_data_src, reg_wren, ram_wren, redirect;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_valid               (in_valid),
        .flush                  (flush),
        .in_pc_data             (in_pc_data),
        .in_rs1_data            (in_rs1_data),
        .in_rs2_data            (in_rs2_data),
        .in_imm                 (in_imm),
        .in_rd_address          (in_rd_address),
        .in_alu_rd_operator     (in_alu_rd_operator),
        .in_alu_rd_operand1_src (in_alu_rd_operand1_src),
        .in_alu_rd_operand2_src (in_alu_rd_operand2_src),
        .in_alu_pc_operand1_src (in_alu_pc_operand1_src),
        .in_next_pc_src         (in_next_pc_src),
        .in_reg_write_data_src  (in_reg_write_data_src),
        .in_reg_wren            (in_reg_wren),
        .in_ram_wren            (in_ram_wren),
        .stall                  (stall),
        .out_valid              (out_valid),
        .alu_result             (alu_result),
        .ram_write_data         (ram_write_data),
        .rd_address             (rd_address),
        .reg_write_data_src     (reg_write_data_src),
        .reg_wren               (reg_wren),
        .ram_wren               (ram_wren),
        .redirect               (redirect),
        .jump_target            (jump_target)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        s1;
        logic        s2;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; flush = 0; in_pc_data = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
        in_rd_address = 0; in_alu_rd_operator = 0; in_alu_rd_operand1_src = 0;
        in_alu_rd_operand2_src = 0; in_alu_pc_operand1_src = 0; in_next_pc_src = 0;
        in_reg_write_data_src = 0; in_reg_wren = 0; in_ram_wren = 0;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2);
        clear_inputs();
        in_valid = 1; in_alu_rd_operator = op; in_rs1_data = rs1; in_rs2_data = rs2;
        in_rd_address = 5'd9; in_reg_wren = 1;
    endtask

    // Reference behaviour from the operator definitions, using wide arithmetic
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        int sa, sb;
        p  = longint'(a) * longint'(b);
        sa = int'(a);
        sb = int'(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << (b % 32);
            4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> (b % 32);
            4'd7:  return 32'(sa >>> (b % 32));
            4'd8:  return a | b;
            4'd9:  return a & b;
`ifdef EX_MULDIV_EN
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: return (b == 0) ? a : a % b;
`endif
            4'd14: return b;
            default: return 32'd0;
        endcase
    endfunction

`ifdef EX_MULDIV_EN
    task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int edges;
        int stalls;
        set_alu(op, a, b);
        edges  = 0;
        stalls = 0;
        while (edges < 40) begin
            #1;
            if (stall) stalls++;
            tick();
            edges++;
            if (out_valid) break;
        end
        chk({name, " latency"}, 32'(edges), 32'd33);
        chk({name, " stall cycles"}, 32'(stalls), 32'd32);
        chk({name, " result"}, alu_result, exp);
        chk({name, " reg_wren"}, {31'd0, reg_wren}, 32'd1);
        chk({name, " rd"}, {27'd0, rd_address}, 32'd9);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        reset = 1;
        tick();
        tick();
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset alu_result", alu_result, 32'd0);
        chk("reset jump_target", jump_target, 32'd0);
        chk("reset redirect", {31'd0, redirect}, 32'd0);
        chk("reset wrens", {30'd0, reg_wren, ram_wren}, 32'd0);
        chk("reset rd/store", ram_write_data | {27'd0, rd_address}, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        reset = 0;

        // op, rs1, rs2, pc, imm, s1, s2, expected
        tbl.push_back('{4'd0,  32'd5,          32'd7,          32'd0,     32'd0,          1'b0, 1'b0, 32'd12});
        tbl.push_back('{4'd1,  32'd3,          32'd5,          32'd0,     32'd0,          1'b0, 1'b0, 32'hFFFF_FFFE});
        tbl.push_back('{4'd2,  32'd1,          32'd33,         32'd0,     32'd0,          1'b0, 1'b0, 32'd2});
        tbl.push_back('{4'd3,  32'hFFFF_FFFF,  32'd0,          32'd0,     32'd0,          1'b0, 1'b0, 32'd1});
        tbl.push_back('{4'd4,  32'hFFFF_FFFF,  32'd0,          32'd0,     32'd0,          1'b0, 1'b0, 32'd0});
        tbl.push_back('{4'd5,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'd0,     32'd0,          1'b0, 1'b0, 32'h0FF0_0FF0});
        tbl.push_back('{4'd6,  32'h8000_0000,  32'd31,         32'd0,     32'd0,          1'b0, 1'b0, 32'd1});
        tbl.push_back('{4'd7,  32'h8000_0000,  32'd4,          32'd0,     32'd0,          1'b0, 1'b0, 32'hF800_0000});
        tbl.push_back('{4'd8,  32'h0000_F000,  32'h0000_00FF,  32'd0,     32'd0,          1'b0, 1'b0, 32'h0000_F0FF});
        tbl.push_back('{4'd9,  32'h1234_ABCD,  32'hFFFF_0000,  32'd0,     32'd0,          1'b0, 1'b0, 32'h1234_0000});
        tbl.push_back('{4'd14, 32'd1,          32'd2,          32'd0,     32'hDEAD_BEEF,  1'b0, 1'b1, 32'hDEAD_BEEF});
        tbl.push_back('{4'd15, 32'd1,          32'd2,          32'd0,     32'd0,          1'b0, 1'b0, 32'd0});
        tbl.push_back('{4'd0,  32'd99,         32'd99,         32'h100,   32'd8,          1'b1, 1'b1, 32'h108});
        tbl.push_back('{4'd1,  32'd0,          32'd1,          32'd0,     32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF});
        tbl.push_back('{4'd0,  32'hFFFF_FFFF,  32'd2,          32'd0,     32'd0,          1'b0, 1'b0, 32'd1});
`ifndef EX_MULDIV_EN
        tbl.push_back('{4'd10, 32'd7,          32'd6,          32'd0,     32'd0,          1'b0, 1'b0, 32'd0});
        tbl.push_back('{4'd12, 32'd100,        32'd7,          32'd0,     32'd0,          1'b0, 1'b0, 32'd0});
`endif

        foreach (tbl[i]) begin
            set_alu(tbl[i].op, tbl[i].rs1, tbl[i].rs2);
            in_pc_data = tbl[i].pc;
            in_imm = tbl[i].imm;
            in_alu_rd_operand1_src = tbl[i].s1;
            in_alu_rd_operand2_src = tbl[i].s2;
            in_reg_wren = i[0];
            in_ram_wren = i[1];
            in_rd_address = 5'(i);
            #1;
            chk($sformatf("tbl%0d stall", i), {31'd0, stall}, 32'd0);
            tick();
            chk($sformatf("tbl%0d alu_result", i), alu_result, tbl[i].exp);
            chk($sformatf("tbl%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("tbl%0d wrens", i), {30'd0, reg_wren, ram_wren}, {30'd0, i[0], i[1]});
            chk($sformatf("tbl%0d rd/store", i), {27'd0, rd_address} ^ ram_write_data,
                {27'd0, 5'(i)} ^ tbl[i].rs2);
            chk($sformatf("tbl%0d redirect", i), {31'd0, redirect}, 32'd0);
        end

        // Jump with pc base: one-cycle redirect pulse
        set_alu(4'd5, 32'h55, 32'h66);
        in_pc_data = 32'h100; in_imm = 32'h21; in_next_pc_src = 1;
        tick();
        chk("jump redirect", {31'd0, redirect}, 32'd1);
        chk("jump target", jump_target, 32'h120);
        chk("jump link", alu_result, 32'h104);
        clear_inputs();
        tick();
        chk("jump redirect pulse", {31'd0, redirect}, 32'd0);
        chk("bubble out_valid", {31'd0, out_valid}, 32'd0);

        // Jump with rs1 base and a muldiv opcode that must be ignored
        set_alu(4'd10, 32'h2000_0003, 32'd6);
        in_pc_data = 32'h40; in_imm = 32'h10; in_next_pc_src = 1; in_alu_pc_operand1_src = 1;
        #1;
        chk("jump md stall", {31'd0, stall}, 32'd0);
        tick();
        chk("jump rs1 target", jump_target, 32'h2000_0012);
        chk("jump rs1 link", alu_result, 32'h44);
        chk("jump rs1 valid", {31'd0, out_valid}, 32'd1);

        // Flush turns a live op into a bubble
        set_alu(4'd0, 32'd1, 32'd2);
        in_ram_wren = 1; in_next_pc_src = 1; flush = 1;
        tick();
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush wrens", {30'd0, reg_wren, ram_wren}, 32'd0);
        chk("flush redirect", {31'd0, redirect}, 32'd0);

`ifdef EX_MULDIV_EN
        run_md("mul 7*6", 4'd10, 32'd7, 32'd6, 32'd42);
        set_alu(4'd0, 32'd5, 32'd7);
        tick();
        chk("add after mul", alu_result, 32'd12);
        chk("add after mul valid", {31'd0, out_valid}, 32'd1);
        run_md("divu 100/0", 4'd12, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_md("remu 100/0", 4'd13, 32'd100, 32'd0, 32'd100);
        run_md("divu 100/7", 4'd12, 32'd100, 32'd7, 32'd14);
        run_md("remu 100/7", 4'd13, 32'd100, 32'd7, 32'd2);
        run_md("mulhu max", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        for (int k = 0; k < 6; k++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'(10 + (k % 4));
            a  = $urandom;
            b  = (k == 5) ? 32'd0 : ((k % 2 == 0) ? $urandom : $urandom_range(1, 1000));
            run_md($sformatf("rand md%0d", k), op, a, b, ref_alu(op, a, b));
        end

        // Reset while BUSY at count 10
        set_alu(4'd10, 32'd7, 32'd6);
        repeat (11) tick();
        reset = 1;
        clear_inputs();
        tick();
        chk("mid-busy reset stall", {31'd0, stall}, 32'd0);
        chk("mid-busy reset outputs", alu_result | jump_target | {31'd0, out_valid}, 32'd0);
        reset = 0;
        set_alu(4'd0, 32'd5, 32'd7);
        #1;
        chk("post-reset stall", {31'd0, stall}, 32'd0);
        tick();
        chk("post-reset add", alu_result, 32'd12);
        chk("post-reset valid", {31'd0, out_valid}, 32'd1);
`endif

        // Randomized single-cycle traffic against the reference model
        for (int k = 0; k < 200; k++) begin
            logic [3:0]  op;
            logic [31:0] a, b, e_alu, e_tgt;
            logic        live;
            clear_inputs();
            op = 4'($urandom_range(0, 15));
`ifdef EX_MULDIV_EN
            if (op >= 4'd10 && op <= 4'd13) op = 4'd14;
`endif
            in_alu_rd_operator     = op;
            in_valid               = ($urandom_range(0, 7) != 0);
            flush                  = ($urandom_range(0, 7) == 0);
            in_pc_data             = $urandom;
            in_rs1_data            = $urandom;
            in_rs2_data            = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            in_imm                 = $urandom;
            in_rd_address          = 5'($urandom);
            in_alu_rd_operand1_src = 1'($urandom);
            in_alu_rd_operand2_src = 1'($urandom);
            in_alu_pc_operand1_src = 1'($urandom);
            in_next_pc_src         = ($urandom_range(0, 5) == 0);
            in_reg_wren            = 1'($urandom);
            in_ram_wren            = 1'($urandom);
            live  = in_valid && !flush;
            a     = in_alu_rd_operand1_src ? in_pc_data : in_rs1_data;
            b     = in_alu_rd_operand2_src ? in_imm : in_rs2_data;
            e_alu = in_next_pc_src ? in_pc_data + 32'd4 : ref_alu(op, a, b);
            e_tgt = ((in_alu_pc_operand1_src ? in_rs1_data : in_pc_data) + in_imm) & 32'hFFFF_FFFE;
            #1;
            chk($sformatf("rnd%0d stall", k), {31'd0, stall}, 32'd0);
            tick();
            chk($sformatf("rnd%0d ctrl", k), {28'd0, out_valid, reg_wren, ram_wren, redirect},
                {28'd0, live, live && in_reg_wren, live && in_ram_wren, live && in_next_pc_src});
            if (live) begin
                chk($sformatf("rnd%0d alu op%0d", k, op), alu_result, e_alu);
                chk($sformatf("rnd%0d target", k), jump_target, e_tgt);
                chk($sformatf("rnd%0d rd", k), {27'd0, rd_address}, {27'd0, in_rd_address});
                chk($sformatf("rnd%0d store", k), ram_write_data, in_rs2_data);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
